// File: rtl/ex_mem_pipeline_register_pkg.sv
// Shared types and constants for the EX/MEM pipeline register.
// Defines the control bundle layout, default widths and the $zero register index.
package ex_mem_pipeline_register_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int REG_W_DEF  = 5;
   localparam int CNT_W_DEF  = 16;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Field order of the control group; the MSB holds reg_write.
   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
      logic branch;
      logic mem_read;
      logic mem_write;
      logic zero;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/ex_mem_pipeline_register_pipe_reg_en_clr.sv
// Generic register with async active-high reset, load enable and synchronous clear.
// The clear input takes priority over the enable input.
module pipe_reg_en_clr #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // State register: a clear loads zero even while the enable is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= {W{1'b0}};
      end else if (clr) begin
         q <= {W{1'b0}};
      end else if (en) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/ex_mem_pipeline_register.sv
// EX/MEM pipeline register with stall/flush control, a saturating bubble counter
// and the MEM-stage store-data forwarding select.
module ex_mem_pipeline_register
   import ex_mem_pipeline_register_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_W  = REG_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Stall,
   input  logic              Flush,
   input  logic              RegWriteE,
   input  logic              MemtoRegE,
   input  logic              BranchE,
   input  logic              MemReadE,
   input  logic              MemWriteE,
   input  logic              ZeroE,
   input  logic [DATA_W-1:0] ALUResultE,
   input  logic [DATA_W-1:0] WriteDataE,
   input  logic [DATA_W-1:0] BranchTargetE,
   input  logic [REG_W-1:0]  WriteRegE,
   input  logic [REG_W-1:0]  RtE,
   input  logic              RegWriteW,
   input  logic [REG_W-1:0]  WriteRegW,
   output logic              RegWriteM,
   output logic              MemtoRegM,
   output logic              BranchM,
   output logic              MemReadM,
   output logic              MemWriteM,
   output logic              ZeroM,
   output logic [DATA_W-1:0] ALUResultM,
   output logic [DATA_W-1:0] WriteDataM,
   output logic [DATA_W-1:0] BranchTargetM,
   output logic [REG_W-1:0]  WriteRegM,
   output logic [REG_W-1:0]  RtM,
   output logic              ValidM,
   output logic              ForwardD,
   output logic [CNT_W-1:0]  BubbleCount
);

   logic                  load_en;
   ctrl_t                 ctrl_d;
   ctrl_t                 ctrl_q;
   logic [3*DATA_W-1:0]   data_q;
   logic [2*REG_W-1:0]    idx_q;
   logic [CNT_W-1:0]      bubble_cnt;

   assign load_en = ~Stall;
   assign ctrl_d  = '{reg_write: RegWriteE, mem_to_reg: MemtoRegE, branch: BranchE,
                      mem_read: MemReadE, mem_write: MemWriteE, zero: ZeroE};

   pipe_reg_en_clr #(.W(CTRL_W)) u_ctrl (
      .clk (Clk), .rst (Reset), .en (load_en), .clr (Flush),
      .d   (ctrl_d), .q (ctrl_q)
   );

   pipe_reg_en_clr #(.W(3*DATA_W)) u_data (
      .clk (Clk), .rst (Reset), .en (load_en), .clr (Flush),
      .d   ({ALUResultE, WriteDataE, BranchTargetE}), .q (data_q)
   );

   pipe_reg_en_clr #(.W(2*REG_W)) u_idx (
      .clk (Clk), .rst (Reset), .en (load_en), .clr (Flush),
      .d   ({WriteRegE, RtE}), .q (idx_q)
   );

   // A bubble is just a cleared valid bit; any unstalled load marks a real instruction.
   pipe_reg_en_clr #(.W(1)) u_valid (
      .clk (Clk), .rst (Reset), .en (load_en), .clr (Flush),
      .d   (1'b1), .q (ValidM)
   );

   assign RegWriteM     = ctrl_q.reg_write;
   assign MemtoRegM     = ctrl_q.mem_to_reg;
   assign BranchM       = ctrl_q.branch;
   assign MemReadM      = ctrl_q.mem_read;
   assign MemWriteM     = ctrl_q.mem_write;
   assign ZeroM         = ctrl_q.zero;
   assign ALUResultM    = data_q[3*DATA_W-1:2*DATA_W];
   assign WriteDataM    = data_q[2*DATA_W-1:DATA_W];
   assign BranchTargetM = data_q[DATA_W-1:0];
   assign WriteRegM     = idx_q[2*REG_W-1:REG_W];
   assign RtM           = idx_q[REG_W-1:0];

   // Bubble counter: counts every flush, stalls at all-ones instead of wrapping.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         bubble_cnt <= {CNT_W{1'b0}};
      end else if (Flush && (bubble_cnt != {CNT_W{1'b1}})) begin
         bubble_cnt <= bubble_cnt + CNT_W'(1);
      end else begin
         bubble_cnt <= bubble_cnt;
      end
   end

   assign BubbleCount = bubble_cnt;

   // Store-data forwarding from WB; a bubble or a $zero source never forwards.
   always_comb begin
      ForwardD = 1'b0;
      if (MemWriteM && RegWriteW && (WriteRegW == RtM) && (RtM != REG_W'(REG_ZERO))) begin
         ForwardD = 1'b1;
      end else begin
         ForwardD = 1'b0;
      end
   end

endmodule

// File: tb/tb_ex_mem_pipeline_register.sv
// Directed self-checking bench for ex_mem_pipeline_register.
// A second instance with a 2-bit counter exercises bubble-count saturation.
module tb_ex_mem_pipeline_register;

   logic        Clk = 1'b0;
   logic        Reset, Stall, Flush;
   logic        RegWriteE, MemtoRegE, BranchE, MemReadE, MemWriteE, ZeroE;
   logic [31:0] ALUResultE, WriteDataE, BranchTargetE;
   logic [4:0]  WriteRegE, RtE, WriteRegW;
   logic        RegWriteW;

   logic        RegWriteM, MemtoRegM, BranchM, MemReadM, MemWriteM, ZeroM, ValidM, ForwardD;
   logic [31:0] ALUResultM, WriteDataM, BranchTargetM;
   logic [4:0]  WriteRegM, RtM;
   logic [15:0] BubbleCount;

   logic        s_rw, s_m2r, s_br, s_mr, s_mw, s_z, s_valid, s_fwd;
   logic [31:0] s_alu, s_wd, s_bt;
   logic [4:0]  s_wr, s_rt;
   logic [1:0]  s_cnt;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 Clk = ~Clk;

   ex_mem_pipeline_register dut (
      .Clk (Clk), .Reset (Reset), .Stall (Stall), .Flush (Flush),
      .RegWriteE (RegWriteE), .MemtoRegE (MemtoRegE), .BranchE (BranchE),
      .MemReadE (MemReadE), .MemWriteE (MemWriteE), .ZeroE (ZeroE),
      .ALUResultE (ALUResultE), .WriteDataE (WriteDataE), .BranchTargetE (BranchTargetE),
      .WriteRegE (WriteRegE), .RtE (RtE), .RegWriteW (RegWriteW), .WriteRegW (WriteRegW),
      .RegWriteM (RegWriteM), .MemtoRegM (MemtoRegM), .BranchM (BranchM),
      .MemReadM (MemReadM), .MemWriteM (MemWriteM), .ZeroM (ZeroM),
      .ALUResultM (ALUResultM), .WriteDataM (WriteDataM), .BranchTargetM (BranchTargetM),
      .WriteRegM (WriteRegM), .RtM (RtM), .ValidM (ValidM), .ForwardD (ForwardD),
      .BubbleCount (BubbleCount)
   );

   ex_mem_pipeline_register #(.CNT_W(2)) dut_sat (
      .Clk (Clk), .Reset (Reset), .Stall (Stall), .Flush (Flush),
      .RegWriteE (RegWriteE), .MemtoRegE (MemtoRegE), .BranchE (BranchE),
      .MemReadE (MemReadE), .MemWriteE (MemWriteE), .ZeroE (ZeroE),
      .ALUResultE (ALUResultE), .WriteDataE (WriteDataE), .BranchTargetE (BranchTargetE),
      .WriteRegE (WriteRegE), .RtE (RtE), .RegWriteW (RegWriteW), .WriteRegW (WriteRegW),
      .RegWriteM (s_rw), .MemtoRegM (s_m2r), .BranchM (s_br),
      .MemReadM (s_mr), .MemWriteM (s_mw), .ZeroM (s_z),
      .ALUResultM (s_alu), .WriteDataM (s_wd), .BranchTargetM (s_bt),
      .WriteRegM (s_wr), .RtM (s_rt), .ValidM (s_valid), .ForwardD (s_fwd),
      .BubbleCount (s_cnt)
   );

   // Advance one clock; sampling happens 1 ns after the rising edge.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_all_inputs();
      RegWriteE = 1'b1; MemtoRegE = 1'b1; BranchE = 1'b1; MemReadE = 1'b1;
      MemWriteE = 1'b1; ZeroE = 1'b1;
      ALUResultE = 32'h0000_1234; WriteDataE = 32'hCAFE_F00D; BranchTargetE = 32'h0000_0ABC;
      WriteRegE = 5'd17; RtE = 5'd3;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; RegWriteW = 1'b0; WriteRegW = 5'd0;
      set_all_inputs();
      step();
      Reset = 1'b0;
      step();
      tests_run++;
      if (ALUResultM !== 32'h0000_1234 || ValidM !== 1'b1 || RegWriteM !== 1'b1) begin
         tests_failed++;
         $display("FAIL pre_reset_capture: alu=%h valid=%b rw=%b required alu=00001234 valid=1 rw=1",
                  ALUResultM, ValidM, RegWriteM);
      end
      #3;
      Reset = 1'b1;
      #1;
      tests_run++;
      if ({RegWriteM, MemtoRegM, BranchM, MemReadM, MemWriteM, ZeroM} !== 6'b0 ||
          ALUResultM !== 32'h0 || WriteDataM !== 32'h0 || BranchTargetM !== 32'h0 ||
          WriteRegM !== 5'd0 || RtM !== 5'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: ctrl=%b alu=%h wd=%h bt=%h wr=%0d rt=%0d required all 0",
                  {RegWriteM, MemtoRegM, BranchM, MemReadM, MemWriteM, ZeroM},
                  ALUResultM, WriteDataM, BranchTargetM, WriteRegM, RtM);
      end
      tests_run++;
      if (ValidM !== 1'b0 || BubbleCount !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_valid_count: valid=%b count=%0d required 0 0", ValidM, BubbleCount);
      end
      step();
      Reset = 1'b0;
   endtask

   task automatic test_capture();
      RegWriteE = 1'b0; MemtoRegE = 1'b0; BranchE = 1'b0; MemReadE = 1'b0;
      MemWriteE = 1'b1; ZeroE = 1'b0;
      ALUResultE = 32'h0000_0040; WriteDataE = 32'hDEAD_BEEF; BranchTargetE = 32'h0000_0100;
      WriteRegE = 5'd0; RtE = 5'd8;
      step();
      tests_run++;
      if (ALUResultM !== 32'h0000_0040 || MemWriteM !== 1'b1 || WriteDataM !== 32'hDEAD_BEEF) begin
         tests_failed++;
         $display("FAIL capture_data: alu=%h mw=%b wd=%h required 00000040 1 deadbeef",
                  ALUResultM, MemWriteM, WriteDataM);
      end
      tests_run++;
      if (ValidM !== 1'b1 || RtM !== 5'd8 || BranchTargetM !== 32'h0000_0100 || RegWriteM !== 1'b0) begin
         tests_failed++;
         $display("FAIL capture_misc: valid=%b rt=%0d bt=%h rw=%b required 1 8 00000100 0",
                  ValidM, RtM, BranchTargetM, RegWriteM);
      end
   endtask

   task automatic test_stall();
      logic [31:0] vals [3];
      vals[0] = 32'd1; vals[1] = 32'd2; vals[2] = 32'd3;
      Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ALUResultE = vals[i];
         RtE = 5'd20;
         step();
         tests_run++;
         if (ALUResultM !== 32'h0000_0040 || RtM !== 5'd8 || ValidM !== 1'b1 || BubbleCount !== 16'd0) begin
            tests_failed++;
            $display("FAIL stall_hold_%0d: alu=%h rt=%0d valid=%b count=%0d required 00000040 8 1 0",
                     i, ALUResultM, RtM, ValidM, BubbleCount);
         end
      end
      Stall = 1'b0;
      RtE = 5'd8;
   endtask

   task automatic test_forward();
      // Registered state from the stall test: MemWriteM=1, RtM=8.
      RegWriteW = 1'b1; WriteRegW = 5'd8;
      #1;
      tests_run++;
      if (ForwardD !== 1'b1) begin
         tests_failed++;
         $display("FAIL forward_match: got %b required 1", ForwardD);
      end
      WriteRegW = 5'd9;
      #1;
      tests_run++;
      if (ForwardD !== 1'b0) begin
         tests_failed++;
         $display("FAIL forward_other_reg: got %b required 0", ForwardD);
      end
      WriteRegW = 5'd8; RegWriteW = 1'b0;
      #1;
      tests_run++;
      if (ForwardD !== 1'b0) begin
         tests_failed++;
         $display("FAIL forward_no_regwrite: got %b required 0", ForwardD);
      end
      RtE = 5'd0; MemWriteE = 1'b1;
      step();
      RegWriteW = 1'b1; WriteRegW = 5'd0;
      #1;
      tests_run++;
      if (ForwardD !== 1'b0 || RtM !== 5'd0 || MemWriteM !== 1'b1) begin
         tests_failed++;
         $display("FAIL forward_zero_reg: fwd=%b rt=%0d mw=%b required 0 0 1", ForwardD, RtM, MemWriteM);
      end
   endtask

   task automatic test_flush_stall();
      set_all_inputs();
      RtE = 5'd8;
      step();
      Stall = 1'b1; Flush = 1'b1;
      RegWriteW = 1'b1; WriteRegW = 5'd8;
      step();
      Stall = 1'b0; Flush = 1'b0;
      tests_run++;
      if ({RegWriteM, MemtoRegM, BranchM, MemReadM, MemWriteM, ZeroM} !== 6'b0 || ValidM !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_ctrl: ctrl=%b valid=%b required 000000 0",
                  {RegWriteM, MemtoRegM, BranchM, MemReadM, MemWriteM, ZeroM}, ValidM);
      end
      tests_run++;
      if (ALUResultM !== 32'h0 || RtM !== 5'd0 || WriteRegM !== 5'd0 || BubbleCount !== 16'd1 || ForwardD !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_data_count: alu=%h rt=%0d wr=%0d count=%0d fwd=%b required 0 0 0 1 0",
                  ALUResultM, RtM, WriteRegM, BubbleCount, ForwardD);
      end
      step();
      tests_run++;
      if (ValidM !== 1'b1 || ALUResultM !== 32'h0000_1234 || BubbleCount !== 16'd1) begin
         tests_failed++;
         $display("FAIL after_flush_capture: valid=%b alu=%h count=%0d required 1 00001234 1",
                  ValidM, ALUResultM, BubbleCount);
      end
   endtask

   task automatic test_saturation();
      logic [1:0]  exp_small [5];
      exp_small[0] = 2'd1; exp_small[1] = 2'd2; exp_small[2] = 2'd3;
      exp_small[3] = 2'd3; exp_small[4] = 2'd3;
      Reset = 1'b1;
      #1;
      Reset = 1'b0;
      Flush = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         tests_run++;
         if (s_cnt !== exp_small[i] || BubbleCount !== 16'(i + 1)) begin
            tests_failed++;
            $display("FAIL saturation_%0d: small=%0d wide=%0d required %0d %0d",
                     i, s_cnt, BubbleCount, exp_small[i], i + 1);
         end
      end
      Flush = 1'b0;
   endtask

   task automatic test_reset_mid_stall();
      Stall = 1'b1; Flush = 1'b1;
      set_all_inputs();
      #2;
      Reset = 1'b1;
      #1;
      tests_run++;
      if (BubbleCount !== 16'd0 || s_cnt !== 2'd0 || ValidM !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_flush: count=%0d small=%0d valid=%b required 0 0 0",
                  BubbleCount, s_cnt, ValidM);
      end
      step();
      Reset = 1'b0; Stall = 1'b0; Flush = 1'b0;
      ALUResultE = 32'h0000_5678;
      step();
      tests_run++;
      if (ALUResultM !== 32'h0000_5678 || ValidM !== 1'b1 || BubbleCount !== 16'd0) begin
         tests_failed++;
         $display("FAIL post_reset_capture: alu=%h valid=%b count=%0d required 00005678 1 0",
                  ALUResultM, ValidM, BubbleCount);
      end
   endtask

   initial begin
      test_reset();
      test_capture();
      test_stall();
      test_forward();
      test_flush_stall();
      test_saturation();
      test_reset_mid_stall();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ex_mem_pipeline_register.md
Name: ex_mem_pipeline_register

Overview:
- EX/MEM pipeline register sitting directly upstream of the MEM stage; captures the EX-stage results and control each cycle and presents them to the memory stage.
- Supports hold (stall) and bubble insertion (flush).
- Generates the MEM-stage store-data forwarding select (ForwardD) from its registered Rt and the MEM/WB destination.
- Counts inserted bubbles for debug.

Parameters:
- DATA_W, 32, datapath width of ALU result, store data, branch target.
- REG_W, 5, register-index width.
- CNT_W, 16, width of bubble counter.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Stall  in  1  hold all registered state this cycle.
- Flush  in  1  load a bubble this cycle.
- RegWriteE, MemtoRegE, BranchE, MemReadE, MemWriteE  in  1 each  EX control.
- ZeroE  in  1  ALU zero flag.
- ALUResultE  in  DATA_W  ALU result (memory address).
- WriteDataE  in  DATA_W  forwarded rt value (store data).
- BranchTargetE  in  DATA_W  computed branch target.
- WriteRegE  in  REG_W  destination register.
- RtE  in  REG_W  rt index of the instruction.
- RegWriteW  in  1  MEM/WB RegWrite.
- WriteRegW  in  REG_W  MEM/WB destination.
- RegWriteM, MemtoRegM, BranchM, MemReadM, MemWriteM, ZeroM  out  1 each  registered copies.
- ALUResultM, WriteDataM, BranchTargetM  out  DATA_W  registered copies.
- WriteRegM, RtM  out  REG_W  registered copies.
- ValidM  out  1  stage holds a real instruction.
- ForwardD  out  1  select WB data as store data.
- BubbleCount  out  CNT_W  bubbles inserted since reset.

Behaviour:
- Reset (async, active-high): all outputs 0. ValidM=0, BubbleCount=0. Takes effect immediately and overrides any in-flight capture.
- Normal cycle (Stall=0, Flush=0): on the rising Clk edge every *M output takes its *E input, and ValidM<=1. Latency is 1 cycle.
- Flush=1: bubble load.
  - RegWriteM, MemtoRegM, BranchM, MemReadM, MemWriteM, ZeroM <= 0; ValidM <= 0.
  - Data and index fields <= 0.
  - BubbleCount increments.
- Priority: Flush over Stall. Flush=1 with Stall=1 still loads the bubble.
- Stall=1, Flush=0: all registers hold, including ValidM and BubbleCount.
- BubbleCount saturates at all-ones and never wraps.
- ForwardD is combinational from registered state and WB inputs:
  - ForwardD = MemWriteM & RegWriteW & (WriteRegW == RtM) & (RtM != 0).
  - A bubble (MemWriteM=0) therefore never forwards. A $zero destination never forwards.
- Reset asserted mid-stall or mid-flush: reset wins. Once released, the first edge captures normally.

Decomposition:
- Shared package:
  - pipeline control bundle field order;
  - REG_ZERO constant (5'd0);
  - default widths DATA_W=32, REG_W=5.
- One sub-module, pipe_reg_en_clr: a generic width-parameterised register with async reset, enable and synchronous clear. Instantiate it per field group (control, data, index).
- Counter and ForwardD logic stay in the top module.

Test Plan:
- Reset: assert Reset mid-cycle with ALUResultE=32'h1234 -> all outputs 0 immediately; ValidM=0; BubbleCount=0.
- Capture: ALUResultE=32'h0000_0040, MemWriteE=1, RtE=5'd8, WriteDataE=32'hDEAD_BEEF -> next edge ALUResultM=32'h40, MemWriteM=1, WriteDataM=32'hDEADBEEF, ValidM=1.
- Stall: hold Stall=1 for 3 cycles while ALUResultE changes 1→2→3 -> ALUResultM stays at its pre-stall value; BubbleCount unchanged.
- Flush with Stall: Flush=1 and Stall=1 together -> next edge all control outputs 0, ValidM=0, BubbleCount increments 0→1.
- Forwarding:
  - MemWriteM=1, RtM=8, RegWriteW=1, WriteRegW=8 -> ForwardD=1.
  - Change WriteRegW to 9 -> ForwardD=0.
  - RtM=0 with WriteRegW=0 -> ForwardD=0.
- Saturation: CNT_W=2, flush 5 times -> BubbleCount reads 1, 2, 3, 3, 3.
